// File: rtl/doorlock_pkg.sv
// doorlock_pkg
// Shared definitions for the keypad door-lock slice: FSM state encoding,
// keypad geometry and the helper that sizes the shared down-counter.
// No ports; imported by doorlock_keydec and doorlock_ctrl.
package doorlock_pkg;

    localparam int DIGIT_W  = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROG    = 3'd4,
        ST_DENY    = 3'd5,
        ST_LOCKOUT = 3'd6
    } state_t;

    // Width of a down-counter that can hold the largest of the three
    // cycle counts; one extra bit keeps the load value clear of the top.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/doorlock_keydec.sv
// doorlock_keydec
// Combinational keypad decode shared by keypad blocks.
// Ports:
//   num         in  [9:0] one-hot key strobe, bit k = digit k
//   digit       out [3:0] binary digit of the pressed key (valid with key_valid)
//   key_valid   out       exactly one key bit set
//   key_invalid out       more than one key bit set (still a press)
module doorlock_keydec
    import doorlock_pkg::*;
(
    input  logic [NUM_KEYS-1:0] num,
    output logic [DIGIT_W-1:0]  digit,
    output logic                key_valid,
    output logic                key_invalid
);

    logic multi_hot;

    // Clearing the lowest set bit leaves something only when two or more
    // bits were set, which is the cheap multi-hot test.
    always_comb begin
        digit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (num[k]) digit = DIGIT_W'(k);
        end
        multi_hot   = |(num & (num - {{(NUM_KEYS-1){1'b0}}, 1'b1}));
        key_valid   = (|num) && !multi_hot;
        key_invalid = multi_hot;
    end

endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl
// Keypad door-lock controller with programmable code, failure counting,
// lockout, entry timeout and timed result indication.
// Ports:
//   clock        in        rising-edge clock
//   reset        in        asynchronous active-high reset
//   num          in  [9:0] one-hot key strobe (multi-hot = invalid press)
//   x            in        enter/start strobe
//   prog         in        request code change, honoured only while open
//   out_led_1    out       access granted / programming committed
//   out_led_2    out       access denied or locked out
//   out_lockout  out       lockout active
//   busy         out       any state other than idle
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_4321,
    parameter int          MAX_FAIL       = 3,
    parameter int          LED_CYCLES     = 8,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          LOCKOUT_CYCLES = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] num,
    input  logic                x,
    input  logic                prog,
    output logic                out_led_1,
    output logic                out_led_2,
    output logic                out_lockout,
    output logic                busy
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int IDX_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = timer_width(LED_CYCLES, TIMEOUT_CYCLES, LOCKOUT_CYCLES);

    localparam logic [IDX_W-1:0]  IDX_FULL     = IDX_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAIL);
    // Timed states run for N cycles: loaded with N-1, exit on the cycle at 0.
    localparam logic [TMR_W-1:0]  LED_LOAD     = TMR_W'(LED_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next, idx_inc;
    logic [TMR_W-1:0]    timer, timer_next;
    logic                mismatch, mismatch_next;
    logic [FAIL_W-1:0]   fail_cnt, fail_next, fail_inc;
    logic [CODE_W-1:0]   code, code_next;
    logic [CODE_W-1:0]   shadow, shadow_next, shadow_upd;

    logic [DIGIT_W-1:0]  digit, cur_digit;
    logic                key_valid, key_invalid, key_press, idx_full;

    doorlock_keydec u_keydec (
        .num         (num),
        .digit       (digit),
        .key_valid   (key_valid),
        .key_invalid (key_invalid)
    );

    // Per-position helpers: the stored digit expected at the current index
    // and the shadow code with the current key written at that index.
    always_comb begin
        cur_digit  = '0;
        shadow_upd = shadow;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit                        = code[i*DIGIT_W +: DIGIT_W];
                shadow_upd[i*DIGIT_W +: DIGIT_W] = digit;
            end
        end
        key_press = key_valid || key_invalid;
        idx_full  = (idx == IDX_FULL);
        idx_inc   = idx + 1'b1;
        fail_inc  = fail_cnt + 1'b1;
    end

    // Next-state and datapath update. A key arriving together with x is
    // always recorded before the enter is acted on, in both entry and
    // programming, so the same-cycle digit takes part in the decision.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        timer_next    = timer;
        mismatch_next = mismatch;
        fail_next     = fail_cnt;
        code_next     = code;
        shadow_next   = shadow;

        case (state)
            ST_IDLE: begin
                if (x) begin
                    state_next    = ST_ENTRY;
                    idx_next      = '0;
                    mismatch_next = 1'b0;
                    timer_next    = TIMEOUT_LOAD;
                end
            end

            ST_ENTRY: begin
                if (key_press) begin
                    if (key_invalid || idx_full || (digit != cur_digit))
                        mismatch_next = 1'b1;
                    if (!idx_full)
                        idx_next = idx_inc;
                    timer_next = TIMEOUT_LOAD;
                end
                if (x) begin
                    state_next = ST_CHECK;
                end else if (!key_press) begin
                    if (timer == '0) state_next = ST_IDLE;
                    else             timer_next = timer - 1'b1;
                end
            end

            ST_CHECK: begin
                if (!mismatch && idx_full) begin
                    state_next = ST_OPEN;
                    fail_next  = '0;
                    timer_next = LED_LOAD;
                end else begin
                    fail_next = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_next = ST_LOCKOUT;
                        timer_next = LOCKOUT_LOAD;
                    end else begin
                        state_next = ST_DENY;
                        timer_next = LED_LOAD;
                    end
                end
            end

            ST_OPEN: begin
                if (prog) begin
                    state_next  = ST_PROG;
                    idx_next    = '0;
                    shadow_next = '0;
                    timer_next  = TIMEOUT_LOAD;
                end else if (timer == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            ST_PROG: begin
                if (key_press && (key_invalid || idx_full)) begin
                    state_next = ST_IDLE;
                end else if (x) begin
                    if ((key_press ? idx_inc : idx) == IDX_FULL) begin
                        code_next  = key_press ? shadow_upd : shadow;
                        state_next = ST_OPEN;
                        fail_next  = '0;
                        timer_next = LED_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (key_press) begin
                    shadow_next = shadow_upd;
                    idx_next    = idx_inc;
                    timer_next  = TIMEOUT_LOAD;
                end else if (timer == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            ST_DENY: begin
                if (timer == '0) state_next = ST_IDLE;
                else             timer_next = timer - 1'b1;
            end

            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_next = ST_IDLE;
                    fail_next  = '0;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset restores the factory code and
    // throws away any entry or programming in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            timer    <= '0;
            mismatch <= 1'b0;
            fail_cnt <= '0;
            code     <= DEFAULT_CODE[CODE_W-1:0];
            shadow   <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            timer    <= timer_next;
            mismatch <= mismatch_next;
            fail_cnt <= fail_next;
            code     <= code_next;
            shadow   <= shadow_next;
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        out_led_1   = (state == ST_OPEN);
        out_led_2   = (state == ST_DENY) || (state == ST_LOCKOUT);
        out_lockout = (state == ST_LOCKOUT);
        busy        = (state != ST_IDLE);
    end

endmodule

// File: doc/doorlock_ctrl.md
Name: doorlock_ctrl

Overview:
Parametrised keypad door-lock controller and successor to the fixed two-digit lock. It has a configurable code length and a runtime-programmable code. It counts failed attempts, with lockout after a set number of failures, times out idle entries, and holds the result LEDs for a set number of cycles. It sits between the debounced keypad strobes (one-hot `num`, enter key `x`) and the door/indicator drivers.

Parameters:
- CODE_LEN, 4: digits per code, 1..8.
- DEFAULT_CODE, 32'h0000_4321: reset code, 4 bits per digit (BCD). Digit 0 is in [3:0] and is entered first. Only the low 4*CODE_LEN bits are used.
- MAX_FAIL, 3: consecutive failures that trigger LOCKOUT, ≥1.
- LED_CYCLES, 8: cycles that OPEN/DENY indication is held, ≥1.
- TIMEOUT_CYCLES, 64: keyless cycles in ENTRY/PROG before abort, ≥2.
- LOCKOUT_CYCLES, 32: LOCKOUT duration, ≥1.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- num, input, 10: one-hot key strobe, bit k = digit k. Any nonzero cycle is one key press.
- x, input, 1: enter/start strobe, one cycle per press.
- prog, input, 1: request code change. Honoured only in OPEN.
- out_led_1, output, 1: access granted, or programming committed.
- out_led_2, output, 1: access denied or locked out.
- out_lockout, output, 1: lockout active.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; all outputs go to 0.
  - fail_cnt, digit index, timer and mismatch flag clear.
  - Stored code loads DEFAULT_CODE. Reset mid-operation discards any partial entry or programming.
- Key decode:
  - num exactly one-hot → valid digit 0..9.
  - num nonzero but not one-hot → invalid key. It counts as a press and always mismatches.
- Outputs are a pure decode of the state register (Moore), so there is no combinational input-to-output path.
- States:
  - IDLE: x=1 → ENTRY; clear index, mismatch flag and timer. num ignored.
  - ENTRY: each key press compares against code[idx] and sets mismatch on any difference, invalid key, or idx ≥ CODE_LEN. idx saturates at CODE_LEN. Any key press restarts the timer. x=1 → CHECK. If x and num arrive in the same cycle, the digit is recorded first and included in the check. Timer reaching TIMEOUT_CYCLES → IDLE with no failure counted.
  - CHECK: one cycle. Pass when mismatch=0 and idx==CODE_LEN.
    - Pass → OPEN; fail_cnt clears.
    - Fail → fail_cnt increments. If the new value equals MAX_FAIL → LOCKOUT, else → DENY.
  - OPEN: out_led_1=1 for LED_CYCLES cycles, then IDLE. prog=1 in any OPEN cycle → PROG; clear index and timer; out_led_1 drops.
  - PROG: valid digits shift into a shadow code; idx increments.
    - x=1 with idx==CODE_LEN and no invalid key → commit shadow to the stored code, then OPEN for LED_CYCLES as confirmation.
    - Discard and go to IDLE, stored code unchanged, on any of: x=1 with idx≠CODE_LEN; an invalid key; a key press with idx==CODE_LEN; timeout.
  - DENY: out_led_2=1 for LED_CYCLES cycles, then IDLE.
  - LOCKOUT: out_led_2=1 and out_lockout=1 for LOCKOUT_CYCLES cycles. All inputs ignored. On exit fail_cnt clears and state → IDLE.
- Latency: x in ENTRY sampled at edge n → CHECK after n → OPEN/DENY/LOCKOUT after edge n+1. The LED is therefore visible 2 cycles after the x edge.
- Timer:
  - One shared down-counter, width $clog2 of the largest cycle parameter +1.
  - Loaded on entry to each timed state; the state exits when the counter reaches 0.
  - No wrap-around is possible.
- fail_cnt:
  - Width $clog2(MAX_FAIL+1).
  - Never exceeds MAX_FAIL.
  - A successful open (including OPEN after a PROG commit) leaves it at 0.
- Illegal state encoding → IDLE on the next clock.

Decomposition:
- doorlock_pkg: state encoding constants, digit width (4), and the function computing timer width.
- Sub-module doorlock_keydec: combinational decode of num into digit[3:0], key_valid and key_invalid (multi-hot). It is reused by future keypad blocks.
- The FSM, timer, fail counter and code registers stay in doorlock_ctrl.

Test Plan:
- Defaults; x, keys 1,2,3,4, x → out_led_1 high exactly 8 cycles, starting 2 cycles after the second x; fail_cnt=0.
- x, keys 1,2,3,5, x → out_led_2 for 8 cycles. Repeat twice more → third failure gives out_lockout=1 and out_led_2=1 for 32 cycles. x ignored during lockout. Correct code then opens.
- x, keys 1,2,3, then 64 keyless cycles → return to IDLE, no LEDs, busy=0, fail_cnt unchanged.
- Key num=10'b00_0000_1010 inside an otherwise correct code → DENY; also five digits 1,2,3,4,4 → DENY.
- Open; prog=1; keys 9,8,7,6; x → confirmation out_led_1. Old code 1234 then DENY; 9876 OPEN. Assert reset mid-entry → code stays 1234 (DEFAULT_CODE), state IDLE, outputs 0 immediately.
- Last digit and x in the same cycle (key 4 with x=1) → OPEN; reset asserted during OPEN → out_led_1 drops asynchronously.
